fft_cmult_pipe: RTL and testbench
=================================

# fft_cmult_pipe

Pipelined, parametrised complex multiplier for the FFT butterfly datapath: computes (iRE + j·iIM) × (iW_RE ± j·iW_IM) with fixed-point scaling, round-half-up and saturation. Adds valid/ready flow control, conjugate mode for inverse transforms, a pass-through tag and a sticky overflow flag. It replaces the single-stage complex multiplier between the twiddle ROM and the butterfly adders.

## Interface
- D_BIT, 17, signed data width (input and output)
- W_BIT, 12, signed twiddle width; unity twiddle = 2^(W_BIT-2) (1024 at default)
- TAG_BIT, 10, width of side-band tag (sample index) carried with each sample
- iCLK  in  1  clock; all logic on rising edge
- iRESET  in  1  synchronous, active-high reset
- iVALID  in  1  input sample valid
- oREADY  out  1  block can accept input this cycle
- iRE, iIM  in  D_BIT each  signed data, real/imag
- iW_RE, iW_IM  in  W_BIT each  signed twiddle, real/imag
- iCONJ  in  1  1 = use conj(W) (IFFT), sampled with the sample
- iTAG  in  TAG_BIT  side-band tag
- oVALID  out  1  output sample valid
- iREADY  in  1  downstream accepts output
- oRE, oIM  out  D_BIT each  signed result
- oTAG  out  TAG_BIT  tag aligned with result
- oOVF  out  1  sticky: some result saturated since reset/clear
- iOVF_CLR  in  1  clears oOVF

## Operation
- Transfer in: iVALID & oREADY. Transfer out: oVALID & iREADY.
- Stage 1: register operands, tag, conj; if conj, negate W_IM (−(−2^(W_BIT-1)) is not generated: twiddle source never emits the most-negative code; behaviour for it is undefined).
- Stage 2: four signed products RE·W_RE, IM·W_IM, RE·W_IM, IM·W_RE, width D_BIT+W_BIT.
- Stage 3: pr = RE·W_RE − IM·W_IM, pi = RE·W_IM + IM·W_RE, width D_BIT+W_BIT+1 (no wrap).
- Stage 4: add 2^(SH−1), arithmetic shift right SH = W_BIT−2 (round half toward +inf); saturate to [−2^(D_BIT−1), 2^(D_BIT−1)−1]; set oOVF if either component saturated on a transferred-in sample reaching stage 4.
- Flow control: single global enable en = ~oVALID | iREADY; all stages advance when en; oREADY = en. Bubbles (invalid slots) propagate as valid=0 and are not compressed.
- oOVF: set wins over iOVF_CLR in the same cycle.

## Timing
- Latency: 4 en-cycles from input transfer to oVALID with iREADY held high; throughput 1 sample/cycle.
- Stall: while oVALID & ~iREADY, all stage registers and outputs hold; oREADY = 0 combinationally the same cycle.
- Reset (any time, including mid-stream): next edge all stage valids = 0, oVALID = 0, oOVF = 0, oRE = oIM = 0, oTAG = 0; in-flight samples discarded. oREADY = 1 in the first cycle after reset.
- iCONJ and iTAG travel with their sample; changing them between samples has no effect on earlier samples.
- No combinational path from iVALID to oVALID; only iREADY → oREADY is combinational.

## Structure
- Shared package fft_pkg: D_BIT/W_BIT defaults, SH derivation function, saturate function (pr width → D_BIT, returns value + flag).
- One sub-module natural: fft_round_sat (round + shift + saturate, one instance per component, purely combinational, used in stage 4).
- Stage valids as a 4-bit shift register gated by en.

## Test plan
- Identity: (16384, 0) × W(1024, 0), conj=0 -> (16384, 0) after 4 cycles, oOVF=0.
- 90° rotation and conjugate: (16384, 0) × W(0, 1024): conj=0 -> (0, 16384); conj=1 -> (0, −16384); tags 5 and 6 emerge in order.
- Rounding: (3, 0) × W(512, 0) -> (2, 0); (−3, 0) × W(512, 0) -> (−1, 0).
- Saturation: (65535, 65535) × W(1024, 1024) -> (0, 65535), oOVF=1 and stays 1; iOVF_CLR pulse -> oOVF=0 next cycle; (−65536, −65536) × same -> (0, −65536).
- Backpressure: stream 8 back-to-back samples, drop iREADY for 3 cycles mid-stream -> oREADY low those cycles, outputs held, all 8 results in order with correct tags, none lost or duplicated.
- Reset mid-stream: assert iRESET with 4 samples in flight -> oVALID=0, oOVF=0 next edge; no stale sample emerges afterwards; new sample after release arrives 4 cycles later.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT complex-multiplier datapath.
package fft_pkg;

  localparam int D_BIT_DEF   = 17;
  localparam int W_BIT_DEF   = 12;
  localparam int TAG_BIT_DEF = 10;

  // Working width for the saturation helper; wide enough for any product sum.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] val;
    logic             ovf;
  } sat_t;

  // Unity twiddle is 2^(w_bit-2), so products are rescaled by that shift.
  function automatic int calc_sh(input int w_bit);
    return w_bit - 2;
  endfunction

  // Clamp a signed value to the d_bit signed range; flag when clamped.
  function automatic sat_t saturate(input logic signed [SAT_W-1:0] x,
                                    input int d_bit);
    sat_t r;
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    one   = 1;
    max_v = (one <<< (d_bit - 1)) - one;
    min_v = -(one <<< (d_bit - 1));
    r.val = x;
    r.ovf = 1'b0;
    if (x > max_v) begin
      r.val = max_v;
      r.ovf = 1'b1;
    end else if (x < min_v) begin
      r.val = min_v;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Round half toward +inf, arithmetic shift right by SH, saturate to D_BIT.
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int IN_W  = 30,
  parameter int D_BIT = 17,
  parameter int SH    = 10
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic signed [D_BIT-1:0] y_o,
  output logic                    ovf_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) <<< (SH - 1);

  logic signed [IN_W:0]  sum;
  logic signed [IN_W:0]  shifted;
  logic [SAT_W-1:0]      ext;
  sat_t                  sat;
  logic                  unused_hi;

  // Round, scale back to data range, then clamp.
  always_comb begin
    sum       = {x_i[IN_W-1], x_i};
    sum       = sum + RND;
    shifted   = sum >>> SH;
    ext       = {{(SAT_W-IN_W-1){shifted[IN_W]}}, shifted};
    sat       = saturate($signed(ext), D_BIT);
    y_o       = sat.val[D_BIT-1:0];
    ovf_o     = sat.ovf;
    unused_hi = ^sat.val[SAT_W-1:D_BIT];
  end

endmodule

// File: rtl/fft_cmult_pipe.sv
// Four-stage pipelined complex multiplier (data x twiddle or conj(twiddle))
// with a single global stall enable, tag pass-through and sticky overflow.
// Handshake: a beat moves on a side when its valid and ready are both high in
// the same cycle; oREADY depends only on iREADY and the last-stage valid.
module fft_cmult_pipe
  import fft_pkg::*;
#(
  parameter int D_BIT   = D_BIT_DEF,
  parameter int W_BIT   = W_BIT_DEF,
  parameter int TAG_BIT = TAG_BIT_DEF
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iVALID,
  output logic                      oREADY,
  input  logic signed [D_BIT-1:0]   iRE,
  input  logic signed [D_BIT-1:0]   iIM,
  input  logic signed [W_BIT-1:0]   iW_RE,
  input  logic signed [W_BIT-1:0]   iW_IM,
  input  logic                      iCONJ,
  input  logic [TAG_BIT-1:0]        iTAG,
  output logic                      oVALID,
  input  logic                      iREADY,
  output logic signed [D_BIT-1:0]   oRE,
  output logic signed [D_BIT-1:0]   oIM,
  output logic [TAG_BIT-1:0]        oTAG,
  output logic                      oOVF,
  input  logic                      iOVF_CLR
);

  localparam int SH  = calc_sh(W_BIT);
  localparam int P_W = D_BIT + W_BIT;
  localparam int S_W = P_W + 1;

  logic                     en;
  logic [3:0]               valid_q;

  logic signed [D_BIT-1:0]  s1_re_q, s1_im_q;
  logic signed [W_BIT-1:0]  s1_wre_q, s1_wim_q, s1_wim_d;
  logic [TAG_BIT-1:0]       s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;

  logic signed [P_W-1:0]    p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [P_W-1:0]    p_rr_q, p_ii_q, p_ri_q, p_ir_q;

  logic signed [S_W-1:0]    pr_d, pi_d, pr_q, pi_q;

  logic signed [D_BIT-1:0]  re_d, im_d, re_q, im_q;
  logic                     ovf_re, ovf_im, ovf_q;

  // The whole pipe advances unless the output slot is full and blocked.
  assign en     = ~valid_q[3] | iREADY;
  assign oREADY = en;
  assign oVALID = valid_q[3];
  assign oRE    = re_q;
  assign oIM    = im_q;
  assign oTAG   = out_tag_q;
  assign oOVF   = ovf_q;

  // Per-stage arithmetic; each stage reads only the previous stage registers.
  always_comb begin
    s1_wim_d = iCONJ ? -iW_IM : iW_IM;
    p_rr_d = $signed({{W_BIT{s1_re_q[D_BIT-1]}}, s1_re_q}) *
             $signed({{D_BIT{s1_wre_q[W_BIT-1]}}, s1_wre_q});
    p_ii_d = $signed({{W_BIT{s1_im_q[D_BIT-1]}}, s1_im_q}) *
             $signed({{D_BIT{s1_wim_q[W_BIT-1]}}, s1_wim_q});
    p_ri_d = $signed({{W_BIT{s1_re_q[D_BIT-1]}}, s1_re_q}) *
             $signed({{D_BIT{s1_wim_q[W_BIT-1]}}, s1_wim_q});
    p_ir_d = $signed({{W_BIT{s1_im_q[D_BIT-1]}}, s1_im_q}) *
             $signed({{D_BIT{s1_wre_q[W_BIT-1]}}, s1_wre_q});
    pr_d = $signed({p_rr_q[P_W-1], p_rr_q}) - $signed({p_ii_q[P_W-1], p_ii_q});
    pi_d = $signed({p_ri_q[P_W-1], p_ri_q}) + $signed({p_ir_q[P_W-1], p_ir_q});
  end

  fft_round_sat #(.IN_W(S_W), .D_BIT(D_BIT), .SH(SH)) u_rs_re (
    .x_i   (pr_q),
    .y_o   (re_d),
    .ovf_o (ovf_re)
  );

  fft_round_sat #(.IN_W(S_W), .D_BIT(D_BIT), .SH(SH)) u_rs_im (
    .x_i   (pi_q),
    .y_o   (im_d),
    .ovf_o (ovf_im)
  );

  // Stage registers and valid shift register, all gated by the global enable.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      valid_q   <= '0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_wre_q  <= '0;
      s1_wim_q  <= '0;
      s1_tag_q  <= '0;
      p_rr_q    <= '0;
      p_ii_q    <= '0;
      p_ri_q    <= '0;
      p_ir_q    <= '0;
      s2_tag_q  <= '0;
      pr_q      <= '0;
      pi_q      <= '0;
      s3_tag_q  <= '0;
      re_q      <= '0;
      im_q      <= '0;
      out_tag_q <= '0;
    end else if (en) begin
      valid_q   <= {valid_q[2:0], iVALID};
      s1_re_q   <= iRE;
      s1_im_q   <= iIM;
      s1_wre_q  <= iW_RE;
      s1_wim_q  <= s1_wim_d;
      s1_tag_q  <= iTAG;
      p_rr_q    <= p_rr_d;
      p_ii_q    <= p_ii_d;
      p_ri_q    <= p_ri_d;
      p_ir_q    <= p_ir_d;
      s2_tag_q  <= s1_tag_q;
      pr_q      <= pr_d;
      pi_q      <= pi_d;
      s3_tag_q  <= s2_tag_q;
      re_q      <= re_d;
      im_q      <= im_d;
      out_tag_q <= s3_tag_q;
    end
  end

  // Sticky overflow: a saturating valid sample entering the last stage sets
  // it, and a set in the same cycle as a clear wins.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      ovf_q <= 1'b0;
    end else if (en && valid_q[2] && (ovf_re || ovf_im)) begin
      ovf_q <= 1'b1;
    end else if (iOVF_CLR) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_cmult_pipe.sv
// Directed bench for fft_cmult_pipe: identity, rotation/conjugate, rounding,
// saturation with sticky flag, backpressure stream, mid-stream reset.
module tb_fft_cmult_pipe;

  localparam int DB = 17;
  localparam int WB = 12;
  localparam int TB = 10;
  localparam int EW = 2*DB + TB;

  logic                 clk;
  logic                 rst;
  logic                 i_valid;
  logic                 o_ready;
  logic signed [DB-1:0] i_re, i_im;
  logic signed [WB-1:0] w_re, w_im;
  logic                 conj;
  logic [TB-1:0]        i_tag;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [DB-1:0] o_re, o_im;
  logic [TB-1:0]        o_tag;
  logic                 o_ovf;
  logic                 ovf_clr;

  int checks;
  int errors;

  logic [EW-1:0] exp_q[$];

  fft_cmult_pipe #(.D_BIT(DB), .W_BIT(WB), .TAG_BIT(TB)) dut (
    .iCLK     (clk),
    .iRESET   (rst),
    .iVALID   (i_valid),
    .oREADY   (o_ready),
    .iRE      (i_re),
    .iIM      (i_im),
    .iW_RE    (w_re),
    .iW_IM    (w_im),
    .iCONJ    (conj),
    .iTAG     (i_tag),
    .oVALID   (o_valid),
    .iREADY   (i_ready),
    .oRE      (o_re),
    .oIM      (o_im),
    .oTAG     (o_tag),
    .oOVF     (o_ovf),
    .iOVF_CLR (ovf_clr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; ovf_clr = 1'b0;
    i_re = '0; i_im = '0; w_re = '0; w_im = '0; conj = 1'b0; i_tag = '0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  // Driver: push one sample, then wait (bounded) for a result.
  task automatic send_and_get(input logic signed [DB-1:0] re, im,
                              input logic signed [WB-1:0] wre, wim,
                              input logic c, input logic [TB-1:0] tag,
                              output logic signed [DB-1:0] ore, oim,
                              output logic [TB-1:0] otag, output int lat);
    @(negedge clk);
    i_valid = 1'b1; i_re = re; i_im = im; w_re = wre; w_im = wim;
    conj = c; i_tag = tag;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ore = o_re; oim = o_im; otag = o_tag;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", o_ovf); end
    checks++; if (o_re !== '0 || o_im !== '0 || o_tag !== '0) begin
      errors++; $display("FAIL reset_data got=%0d,%0d,%0d exp=0,0,0", o_re, o_im, o_tag);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_identity();
    logic signed [DB-1:0] r, im; logic [TB-1:0] t; int lat;
    send_and_get(17'sd16384, 17'sd0, 12'sd1024, 12'sd0, 1'b0, 10'd1, r, im, t, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ident_latency got=%0d exp=4", lat); end
    checks++; if (r !== 17'sd16384 || im !== 17'sd0) begin
      errors++; $display("FAIL ident_data got=%0d,%0d exp=16384,0", r, im);
    end
    checks++; if (t !== 10'd1) begin errors++; $display("FAIL ident_tag got=%0d exp=1", t); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ident_ovf got=%b exp=0", o_ovf); end
  endtask

  task automatic test_rotation_conj();
    logic signed [DB-1:0] gr[2]; logic signed [DB-1:0] gi[2]; logic [TB-1:0] gt[2];
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1; i_re = 17'sd16384; i_im = 17'sd0; w_re = 12'sd0; w_im = 12'sd1024;
    conj = 1'b0; i_tag = 10'd5;
    @(negedge clk);
    conj = 1'b1; i_tag = 10'd6;
    @(negedge clk);
    i_valid = 1'b0; conj = 1'b0; i_tag = 10'd0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (o_valid && n < 2) begin gr[n] = o_re; gi[n] = o_im; gt[n] = o_tag; n++; end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL rot_count got=%0d exp=2", n); end
    checks++; if (gt[0] !== 10'd5 || gt[1] !== 10'd6) begin
      errors++; $display("FAIL rot_tags got=%0d,%0d exp=5,6", gt[0], gt[1]);
    end
    checks++; if (gr[0] !== 17'sd0 || gi[0] !== 17'sd16384) begin
      errors++; $display("FAIL rot_plain got=%0d,%0d exp=0,16384", gr[0], gi[0]);
    end
    checks++; if (gr[1] !== 17'sd0 || gi[1] !== -17'sd16384) begin
      errors++; $display("FAIL rot_conj got=%0d,%0d exp=0,-16384", gr[1], gi[1]);
    end
  endtask

  task automatic test_rounding();
    logic signed [DB-1:0] r, im; logic [TB-1:0] t; int lat;
    send_and_get(17'sd3, 17'sd0, 12'sd512, 12'sd0, 1'b0, 10'd7, r, im, t, lat);
    checks++; if (r !== 17'sd2 || im !== 17'sd0) begin
      errors++; $display("FAIL round_pos got=%0d,%0d exp=2,0", r, im);
    end
    send_and_get(-17'sd3, 17'sd0, 12'sd512, 12'sd0, 1'b0, 10'd8, r, im, t, lat);
    checks++; if (r !== -17'sd1 || im !== 17'sd0) begin
      errors++; $display("FAIL round_neg got=%0d,%0d exp=-1,0", r, im);
    end
  endtask

  task automatic test_saturation();
    logic signed [DB-1:0] r, im; logic [TB-1:0] t; int lat;
    send_and_get(17'sd65535, 17'sd65535, 12'sd1024, 12'sd1024, 1'b0, 10'd9, r, im, t, lat);
    checks++; if (r !== 17'sd0 || im !== 17'sd65535) begin
      errors++; $display("FAIL sat_pos got=%0d,%0d exp=0,65535", r, im);
    end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set got=%b exp=1", o_ovf); end
    repeat (3) @(posedge clk); #1;
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got=%b exp=1", o_ovf); end
    @(negedge clk); ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr got=%b exp=0", o_ovf); end
    send_and_get(17'h10000, 17'h10000, 12'sd1024, 12'sd1024, 1'b0, 10'd10, r, im, t, lat);
    checks++; if (r !== 17'sd0 || im !== 17'h10000) begin
      errors++; $display("FAIL sat_neg got=%0d,%0d exp=0,-65536", r, im);
    end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf got=%b exp=1", o_ovf); end
    @(negedge clk); ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    fork
      begin : producer
        int sent; int cyc;
        logic signed [DB-1:0] er, ei;
        sent = 0; cyc = 0;
        while (sent < 8 && cyc < 60) begin
          @(negedge clk);
          i_valid = 1'b1;
          i_re  = DB'(1000 * (sent + 1));
          i_im  = DB'(-300 * sent);
          w_re  = 12'sd0;
          w_im  = 12'sd1024;
          conj  = sent[0];
          i_tag = TB'(20 + sent);
          #1;
          if (o_ready) begin
            // x*j rotates (a,b) to (-b,a); x*(-j) rotates it to (b,-a).
            if (conj) begin er = i_im; ei = -i_re; end
            else begin er = -i_im; ei = i_re; end
            exp_q.push_back({i_tag, er, ei});
            sent++;
          end
          cyc++;
        end
        @(negedge clk); i_valid = 1'b0;
      end
      begin : consumer
        int got; int cyc; logic stalled; logic [EW-1:0] held; logic [EW-1:0] e;
        got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 8 && cyc < 60) begin
          @(negedge clk);
          i_ready = !(cyc >= 6 && cyc <= 8);
          #1;
          if (stalled) begin
            checks++;
            if ({o_tag, o_re, o_im} !== held) begin
              errors++; $display("FAIL bp_hold got=%h exp=%h", {o_tag, o_re, o_im}, held);
            end
          end
          if (o_valid && !i_ready) begin
            checks++;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", o_ready); end
            held = {o_tag, o_re, o_im};
            stalled = 1'b1;
          end else begin
            stalled = 1'b0;
          end
          if (o_valid && i_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL bp_extra got=%h exp=none", {o_tag, o_re, o_im});
            end else begin
              e = exp_q.pop_front();
              if ({o_tag, o_re, o_im} !== e) begin
                errors++; $display("FAIL bp_data got=%h exp=%h", {o_tag, o_re, o_im}, e);
              end
            end
            got++;
          end
          cyc++;
        end
        i_ready = 1'b1;
        checks++;
        if (got !== 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got); end
      end
    join
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got=%b exp=0", o_valid); end
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    logic signed [DB-1:0] r, im; logic [TB-1:0] t; int lat; int stale;
    send_and_get(17'sd65535, 17'sd65535, 12'sd1024, 12'sd1024, 1'b0, 10'd30, r, im, t, lat);
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL mid_ovf_pre got=%b exp=1", o_ovf); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_re = 17'sd500; i_im = 17'sd0; w_re = 12'sd1024; w_im = 12'sd0;
      conj = 1'b0; i_tag = TB'(40 + k);
    end
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", o_valid); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", o_ovf); end
    checks++; if (o_re !== '0 || o_tag !== '0) begin
      errors++; $display("FAIL mid_data got=%0d,%0d exp=0,0", o_re, o_tag);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", o_ready); end
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got=%0d exp=0", stale); end
    send_and_get(17'sd777, -17'sd123, 12'sd1024, 12'sd0, 1'b0, 10'd50, r, im, t, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_latency got=%0d exp=4", lat); end
    checks++; if (r !== 17'sd777 || im !== -17'sd123 || t !== 10'd50) begin
      errors++; $display("FAIL mid_new got=%0d,%0d,%0d exp=777,-123,50", r, im, t);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; ovf_clr = 1'b0;
    i_re = '0; i_im = '0; w_re = '0; w_im = '0; conj = 1'b0; i_tag = '0;
    test_reset();
    test_identity();
    test_rotation_conj();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
